// File: rtl/ls_order_unit_pkg.sv
// Shared tag encoding and slot helpers for the load/store ordering unit.
package ls_order_unit_pkg;

  localparam int LSQ_DEPTH = 5;
  localparam int ADDR_W    = 64;
  localparam int TAG_W     = 4;
  localparam int NUM_SLOTS = 5;

  localparam logic [TAG_W-1:0] NOTAG  = 4'd0;
  localparam logic [TAG_W-1:0] ADD_1  = 4'd1;
  localparam logic [TAG_W-1:0] ADD_2  = 4'd2;
  localparam logic [TAG_W-1:0] ADD_3  = 4'd3;
  localparam logic [TAG_W-1:0] MULT_1 = 4'd4;
  localparam logic [TAG_W-1:0] MULT_2 = 4'd5;
  localparam logic [TAG_W-1:0] LD_1   = 4'd6;
  localparam logic [TAG_W-1:0] LD_2   = 4'd7;
  localparam logic [TAG_W-1:0] LD_3   = 4'd8;
  localparam logic [TAG_W-1:0] ST_1   = 4'd9;
  localparam logic [TAG_W-1:0] ST_2   = 4'd10;

  // Memory-slot index of a load/store tag: st_1=0, st_2=1, ld_1=2, ld_2=3, ld_3=4.
  function automatic logic [2:0] tag_to_slot(input logic [TAG_W-1:0] tag);
    logic [2:0] slot;
    case (tag)
      ST_1:    slot = 3'd0;
      ST_2:    slot = 3'd1;
      LD_1:    slot = 3'd2;
      LD_2:    slot = 3'd3;
      LD_3:    slot = 3'd4;
      default: slot = 3'd0;
    endcase
    return slot;
  endfunction

  function automatic logic is_store(input logic [TAG_W-1:0] tag);
    return (tag == ST_1) || (tag == ST_2);
  endfunction

  // Only load/store tags may enter the ordering unit.
  function automatic logic is_mem_tag(input logic [TAG_W-1:0] tag);
    return (tag >= LD_1) && (tag <= ST_2);
  endfunction

endpackage

// File: rtl/ls_tag_fifo.sv
// In-order FIFO of issued load/store tags awaiting address calculation.
module ls_tag_fifo
  import ls_order_unit_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] push_tag,
  input  logic [TAG_W-1:0] query_tag,
  output logic             query_hit,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    head_ptr_reg;
  logic [PW-1:0]    tail_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] live_hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is visible combinationally so the RS can be addressed this cycle.
  assign head_tag = empty ? NOTAG : mem_reg[head_ptr_reg];

  // A storage location is live if it lies within count entries of the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
    logic live;
    assign live = ((int'(head_ptr_reg) <= gi) ? (gi - int'(head_ptr_reg))
                                              : (gi + DEPTH - int'(head_ptr_reg)))
                  < int'(count_reg);
    assign live_hit[gi] = live && (mem_reg[gi] == query_tag);
  end
  assign query_hit = |live_hit;

  // Tag storage: written at the tail; stale contents are masked by the live test.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[tail_ptr_reg] <= push_tag;
    end
  end

  // Pointer and occupancy update; both pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (do_push) tail_ptr_reg <= ptr_inc(tail_ptr_reg);
      if (do_pop)  head_ptr_reg <= ptr_inc(head_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ls_order_unit.sv
// Memory-ordering core: tag FIFO, effective-address adder, age-ordered list and
// oldest-eligible selection of the slot sent to memory.
module ls_order_unit
  import ls_order_unit_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TAG_W-1:0]        tag_in,
  input  logic                    wr_en,
  input  logic                    aff_ready,
  input  logic [AW-1:0]           op,
  input  logic [AW-1:0]           offset,
  input  logic [NUM_SLOTS-1:0]    ready_bus,
  input  logic [NUM_SLOTS*AW-1:0] address_bus,
  input  logic                    remove,
  output logic [TAG_W-1:0]        head_tag,
  output logic [AW-1:0]           address,
  output logic [TAG_W-1:0]        mem_tag,
  output logic                    lsq_full,
  output logic                    lsq_empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] list_tag_reg  [DEPTH];
  logic [TAG_W-1:0] list_tag_next [DEPTH];
  logic [CW-1:0]    list_cnt_reg;
  logic [CW-1:0]    list_cnt_next;

  logic [AW-1:0]    slot_addr   [NUM_SLOTS];
  logic [AW-1:0]    entry_addr  [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_store;
  logic [DEPTH-1:0] entry_elig;
  logic [DEPTH-1:0] entry_match;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_hit;
  logic             list_hit;
  logic             sel_found;
  logic [CW-1:0]    sel_idx;
  logic             do_remove;

  // Effective address of the head entry, wrapping modulo 2^AW.
  assign address = op + offset;

  // A new tag is accepted only if it is a load/store tag not already in flight.
  assign fifo_push = wr_en && !lsq_full && is_mem_tag(tag_in) && !fifo_hit && !list_hit;
  assign fifo_pop  = aff_ready && !lsq_empty;

  ls_tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_tag  (tag_in),
    .query_tag (tag_in),
    .query_hit (fifo_hit),
    .head_tag  (head_tag),
    .full      (lsq_full),
    .empty     (lsq_empty)
  );

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign slot_addr[gi] = address_bus[gi*AW +: AW];
  end

  // Per-entry view: validity, address, type and the store/load hazard against older entries.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DEPTH-1:0] older_conflict;
    assign entry_valid[gi] = (CW'(gi) < list_cnt_reg);
    assign entry_addr[gi]  = slot_addr[tag_to_slot(list_tag_reg[gi])];
    assign entry_store[gi] = is_store(list_tag_reg[gi]);
    assign entry_match[gi] = entry_valid[gi] && (list_tag_reg[gi] == tag_in);
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_older
      if (gj < gi) begin : g_chk
        assign older_conflict[gj] = entry_valid[gj]
                                    && (entry_addr[gj] == entry_addr[gi])
                                    && (entry_store[gj] || entry_store[gi]);
      end else begin : g_none
        assign older_conflict[gj] = 1'b0;
      end
    end
    assign entry_elig[gi] = entry_valid[gi]
                            && ready_bus[tag_to_slot(list_tag_reg[gi])]
                            && !(|older_conflict);
  end

  assign list_hit = |entry_match;

  // Oldest eligible entry wins; scan from youngest so the lowest index is kept.
  always_comb begin
    sel_idx   = '0;
    sel_found = |entry_elig;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entry_elig[i]) sel_idx = CW'(i);
    end
  end

  assign mem_tag   = sel_found ? list_tag_reg[sel_idx] : NOTAG;
  assign do_remove = remove && sel_found;

  // Next list: delete the retired entry and compact, then append the popped FIFO head.
  always_comb begin
    list_cnt_next = list_cnt_reg;
    for (int i = 0; i < DEPTH; i++) begin
      list_tag_next[i] = list_tag_reg[i];
    end
    if (do_remove) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= sel_idx) list_tag_next[i] = list_tag_reg[i+1];
      end
      list_tag_next[DEPTH-1] = NOTAG;
      list_cnt_next          = list_cnt_reg - 1'b1;
    end
    if (fifo_pop && (list_cnt_next < CW'(DEPTH))) begin
      list_tag_next[list_cnt_next] = head_tag;
      list_cnt_next                = list_cnt_next + 1'b1;
    end
  end

  // Order-list state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      list_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        list_tag_reg[i] <= NOTAG;
      end
    end else begin
      list_cnt_reg <= list_cnt_next;
      for (int i = 0; i < DEPTH; i++) begin
        list_tag_reg[i] <= list_tag_next[i];
      end
    end
  end

endmodule

// File: tb/tb_ls_order_unit.sv
// Directed bench for ls_order_unit with a queue-based model of the FIFO and order list.
module tb_ls_order_unit;

  logic         clk;
  logic         rst;
  logic [3:0]   tag_in;
  logic         wr_en;
  logic         aff_ready;
  logic [63:0]  op;
  logic [63:0]  offset;
  logic [4:0]   ready_bus;
  logic [319:0] address_bus;
  logic         remove;
  logic [3:0]   head_tag;
  logic [63:0]  address;
  logic [3:0]   mem_tag;
  logic         lsq_full;
  logic         lsq_empty;

  int total;
  int bad;

  logic [3:0] mq[$];       // model tag FIFO
  logic [3:0] ml[$];       // model order list
  logic [3:0] exp_mem_q[$]; // expected mem_tag values awaiting comparison

  ls_order_unit dut (
    .clk         (clk),
    .rst         (rst),
    .tag_in      (tag_in),
    .wr_en       (wr_en),
    .aff_ready   (aff_ready),
    .op          (op),
    .offset      (offset),
    .ready_bus   (ready_bus),
    .address_bus (address_bus),
    .remove      (remove),
    .head_tag    (head_tag),
    .address     (address),
    .mem_tag     (mem_tag),
    .lsq_full    (lsq_full),
    .lsq_empty   (lsq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  function automatic logic in_q(input logic [3:0] q[$], input logic [3:0] t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 4'd0;
  endfunction

  task automatic expect_mem(input logic [3:0] t);
    exp_mem_q.push_back(t);
  endtask

  task automatic check_mem(input string name);
    logic [3:0] e;
    if (exp_mem_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s observed=%0h expected=<none queued>", name, mem_tag);
    end else begin
      e = exp_mem_q.pop_front();
      chk(name, {60'd0, mem_tag}, {60'd0, e});
    end
  endtask

  // One clock with the given controls; rm_tag is the entry the bench expects to retire.
  task automatic cycle(input logic w, input logic [3:0] t, input logic a,
                       input logic r, input logic [3:0] rm_tag);
    logic acc;
    wr_en = w; tag_in = t; aff_ready = a; remove = r;
    acc = w && (t >= 4'd6) && (t <= 4'd10) && (mq.size() < 5) && !in_q(mq, t) && !in_q(ml, t);
    if (r && rm_tag != 4'd0) begin
      foreach (ml[i]) if (ml[i] == rm_tag) begin ml.delete(i); break; end
    end
    if (a && mq.size() != 0) ml.push_back(mq.pop_front());
    if (acc) mq.push_back(t);
    @(posedge clk);
    #1;
    wr_en = 1'b0; tag_in = 4'd0; aff_ready = 1'b0; remove = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b1; tag_in = 4'd7; aff_ready = 1'b1; remove = 1'b1;
    ready_bus = 5'b11111;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; tag_in = 4'd0; aff_ready = 1'b0; remove = 1'b0;
    ready_bus = 5'b00000;
    mq.delete();
    ml.delete();
    #1;
  endtask

  task automatic set_slot(input int s, input logic [63:0] a);
    address_bus[s*64 +: 64] = a;
  endtask

  logic [3:0] free_tag;
  logic [3:0] e_tag;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; wr_en = 1'b0; tag_in = 4'd0; aff_ready = 1'b0; remove = 1'b0;
    op = 64'd0; offset = 64'd0; ready_bus = 5'd0; address_bus = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_head", {60'd0, head_tag}, 64'd0);
    expect_mem(4'd0);
    check_mem("rst_mem");
    chk("rst_empty", {63'd0, lsq_empty}, 64'd1);
    chk("rst_full", {63'd0, lsq_full}, 64'd0);

    // Adder, including wrap-around
    op = 64'h1000; offset = 64'h18; #1;
    chk("addr_basic", address, 64'h1018);
    op = 64'hFFFF_FFFF_FFFF_FFF8; offset = 64'h10; #1;
    chk("addr_wrap", address, 64'h8);

    // Invalid tag is ignored
    cycle(1'b1, 4'd3, 1'b0, 1'b0, 4'd0);
    chk("bad_tag_empty", {63'd0, lsq_empty}, 64'd1);

    // Push 6, 9, 7 on consecutive cycles
    cycle(1'b1, 4'd6, 1'b0, 1'b0, 4'd0);
    chk("push1_head", {60'd0, head_tag}, {60'd0, exp_head()});
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 4'd0);
    cycle(1'b1, 4'd7, 1'b0, 1'b0, 4'd0);
    chk("push3_head", {60'd0, head_tag}, {60'd0, exp_head()});
    chk("push3_full", {63'd0, lsq_full}, 64'd0);
    chk("push3_empty", {63'd0, lsq_empty}, 64'd0);

    // Ordering without conflict
    do_reset();
    chk("rst2_head", {60'd0, head_tag}, 64'd0);
    set_slot(2, 64'h100); set_slot(3, 64'h200);
    cycle(1'b1, 4'd6, 1'b0, 1'b0, 4'd0);
    cycle(1'b1, 4'd7, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    chk("pop1_head", {60'd0, head_tag}, {60'd0, exp_head()});
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    chk("pop2_empty", {63'd0, lsq_empty}, 64'd1);
    ready_bus = 5'b01100; #1;
    expect_mem(4'd6);
    check_mem("order_oldest");
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd6);
    expect_mem(4'd7);
    check_mem("order_after_remove");
    ready_bus = 5'b00000; #1;
    expect_mem(4'd0);
    check_mem("order_none_ready");
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
    ready_bus = 5'b01100; #1;
    expect_mem(4'd7);
    check_mem("remove_ignored");

    // Store-load hazard
    do_reset();
    set_slot(0, 64'h100); set_slot(2, 64'h100);
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 4'd0);
    cycle(1'b1, 4'd6, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    ready_bus = 5'b00100; #1;
    expect_mem(4'd0);
    check_mem("hazard_blocked");
    ready_bus = 5'b00101; #1;
    expect_mem(4'd9);
    check_mem("hazard_store_first");
    set_slot(2, 64'h180); ready_bus = 5'b00100; #1;
    expect_mem(4'd6);
    check_mem("hazard_diff_addr");

    // Full FIFO and pointer wrap
    do_reset();
    for (int s = 0; s < 5; s++) set_slot(s, 64'h1000 + 64'(s) * 64'h40);
    for (int t = 6; t <= 10; t++) cycle(1'b1, 4'(t), 1'b0, 1'b0, 4'd0);
    chk("full_set", {63'd0, lsq_full}, 64'd1);
    cycle(1'b1, 4'd6, 1'b0, 1'b0, 4'd0);
    chk("full_drop_head", {60'd0, head_tag}, {60'd0, exp_head()});
    chk("full_drop_full", {63'd0, lsq_full}, 64'd1);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    ready_bus = 5'b11111; #1;
    expect_mem(ml[0]);
    check_mem("wrap_pre_mem");
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd6);
    free_tag = 4'd6;
    for (int k = 0; k < 10; k++) begin
      e_tag = ml[0];
      expect_mem(e_tag);
      check_mem($sformatf("wrap%0d_mem", k));
      cycle(1'b1, free_tag, 1'b1, 1'b1, e_tag);
      free_tag = e_tag;
      chk($sformatf("wrap%0d_head", k), {60'd0, head_tag}, {60'd0, exp_head()});
      chk($sformatf("wrap%0d_full", k), {63'd0, lsq_full}, 64'd0);
    end

    // Append and retire in the same edge
    e_tag = ml[0];
    cycle(1'b0, 4'd0, 1'b1, 1'b1, e_tag);
    expect_mem(ml[0]);
    check_mem("simul_mem");
    chk("simul_head", {60'd0, head_tag}, {60'd0, exp_head()});

    // Reset dominates same-cycle push/pop/remove
    do_reset();
    chk("rst3_head", {60'd0, head_tag}, 64'd0);
    ready_bus = 5'b11111; #1;
    expect_mem(4'd0);
    check_mem("rst3_mem");
    chk("rst3_empty", {63'd0, lsq_empty}, 64'd1);
    chk("rst3_full", {63'd0, lsq_full}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
